imem_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the instruction RAM in the single-cycle RISC-V core. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them sequentially into the instruction RAM write port from word 0. It holds the CPU in reset until the whole image is written, then releases it. An out-of-range image length is flagged and the CPU stays in reset.

---
 rtl/imem_loader.sv | 196 +++++++++++++++++++
 tb/tb_imem_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the instruction RAM.
// Takes a byte stream (2-byte little-endian word count, then the payload),
// packs little-endian 32-bit words and writes them from word 0 upward.
// The CPU is held in reset until the whole image has been written.
module imem_loader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_wr_en,
    output logic [ADDR_W-1:0] imem_wr_addr,
    output logic [DATA_W-1:0] imem_wr_data,
    output logic              cpu_rst_n,
    output logic              load_err,
    output logic [15:0]       words_loaded
);

    typedef enum logic [2:0] {
        ST_LEN_LO = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LOAD   = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR    = 3'd4
    } state_t;

    localparam logic [15:0] DEPTH_L = 16'(DEPTH);

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [15:0]         word_idx_q, word_idx_d;
    logic [23:0]         buf_q, buf_d;          // lanes 0..2; lane 3 arrives with the write
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                cpu_rst_n_q, cpu_rst_n_d;
    logic                load_err_q, load_err_d;
    logic [15:0]         words_loaded_q, words_loaded_d;

    logic                in_ready_s;
    logic                xfer_s;
    logic [15:0]         hdr_len_s;
    logic                last_word_s;

    assign xfer_s      = in_valid & in_ready_s;
    assign hdr_len_s   = {in_data, len_q[7:0]};
    assign last_word_s = (word_idx_q == (len_q - 16'd1));

    // State register and datapath flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_LEN_LO;
            len_q          <= 16'd0;
            byte_idx_q     <= 2'd0;
            word_idx_q     <= 16'd0;
            buf_q          <= 24'd0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            cpu_rst_n_q    <= 1'b0;
            load_err_q     <= 1'b0;
            words_loaded_q <= 16'd0;
        end else begin
            state_q        <= state_d;
            len_q          <= len_d;
            byte_idx_q     <= byte_idx_d;
            word_idx_q     <= word_idx_d;
            buf_q          <= buf_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            cpu_rst_n_q    <= cpu_rst_n_d;
            load_err_q     <= load_err_d;
            words_loaded_q <= words_loaded_d;
        end
    end

    // Next-state logic: header decode, end of image, restart override
    always_comb begin
        state_d = state_q;
        if (restart) begin
            state_d = ST_LEN_LO;
        end else begin
            case (state_q)
                ST_LEN_LO: begin
                    if (xfer_s) state_d = ST_LEN_HI;
                    else        state_d = state_q;
                end
                ST_LEN_HI: begin
                    if (!xfer_s)                   state_d = state_q;
                    else if (hdr_len_s == 16'd0)   state_d = ST_DONE;
                    else if (hdr_len_s > DEPTH_L)  state_d = ST_ERR;
                    else                           state_d = ST_LOAD;
                end
                ST_LOAD: begin
                    if (xfer_s && (byte_idx_q == 2'd3) && last_word_s) state_d = ST_DONE;
                    else                                                 state_d = state_q;
                end
                ST_DONE: state_d = ST_DONE;
                ST_ERR:  state_d = ST_ERR;
                default: state_d = ST_LEN_LO;
            endcase
        end
    end

    // Output decode: in_ready depends only on state, reset and restart
    always_comb begin
        in_ready_s = 1'b0;
        if (!rst_n || restart) begin
            in_ready_s = 1'b0;
        end else begin
            case (state_q)
                ST_LEN_LO, ST_LEN_HI, ST_LOAD: in_ready_s = 1'b1;
                default:                       in_ready_s = 1'b0;
            endcase
        end
    end

    // Datapath next values: header latch, word packing, write strobe, status
    always_comb begin
        len_d          = len_q;
        byte_idx_d     = byte_idx_q;
        word_idx_d     = word_idx_q;
        buf_d          = buf_q;
        wr_en_d        = 1'b0;                 // strobe lasts exactly one cycle
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        cpu_rst_n_d    = (state_q == ST_DONE); // rises the edge after reaching DONE
        load_err_d     = load_err_q;
        words_loaded_d = words_loaded_q;
        if (restart) begin
            byte_idx_d     = 2'd0;
            word_idx_d     = 16'd0;
            words_loaded_d = 16'd0;
            load_err_d     = 1'b0;
            cpu_rst_n_d    = 1'b0;
        end else begin
            case (state_q)
                ST_LEN_LO: begin
                    if (xfer_s) len_d[7:0] = in_data;
                    else        len_d      = len_q;
                end
                ST_LEN_HI: begin
                    if (xfer_s) begin
                        len_d      = hdr_len_s;
                        byte_idx_d = 2'd0;
                        word_idx_d = 16'd0;
                        if (hdr_len_s > DEPTH_L) load_err_d = 1'b1;
                        else                     load_err_d = load_err_q;
                    end else begin
                        len_d = len_q;
                    end
                end
                ST_LOAD: begin
                    if (xfer_s) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        case (byte_idx_q)
                            2'd0: buf_d[7:0]   = in_data;
                            2'd1: buf_d[15:8]  = in_data;
                            2'd2: buf_d[23:16] = in_data;
                            default: begin
                                wr_en_d        = 1'b1;
                                wr_addr_d      = ADDR_W'({word_idx_q, 2'b00});
                                wr_data_d      = DATA_W'({in_data, buf_q});
                                words_loaded_d = words_loaded_q + 16'd1;
                                // Hold on the last word so the index stays below DEPTH
                                if (!last_word_s) word_idx_d = word_idx_q + 16'd1;
                                else              word_idx_d = word_idx_q;
                            end
                        endcase
                    end else begin
                        byte_idx_d = byte_idx_q;
                    end
                end
                default: begin
                    len_d = len_q;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_s;
    assign imem_wr_en   = wr_en_q;
    assign imem_wr_addr = wr_addr_q;
    assign imem_wr_data = wr_data_q;
    assign cpu_rst_n    = cpu_rst_n_q;
    assign load_err     = load_err_q;
    assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        restart = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        imem_wr_en;
    logic [31:0] imem_wr_addr;
    logic [31:0] imem_wr_data;
    logic        cpu_rst_n;
    logic        load_err;
    logic [15:0] words_loaded;

    imem_loader #(.DATA_W(32), .ADDR_W(32), .DEPTH(256)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .restart      (restart),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .imem_wr_en   (imem_wr_en),
        .imem_wr_addr (imem_wr_addr),
        .imem_wr_data (imem_wr_data),
        .cpu_rst_n    (cpu_rst_n),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];
    bit          rel_seen = 1'b0;
    int          rel_cyc = 0;
    int          acc_cyc = 0;
    logic [7:0]  img[$];

    // Write/release monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (imem_wr_en) begin
            wa_q.push_back(imem_wr_addr);
            wd_q.push_back(imem_wr_data);
            wc_q.push_back(cyc);
        end
        if (cpu_rst_n && !rel_seen) begin
            rel_seen = 1'b1;
            rel_cyc  = cyc;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        rel_seen = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check_eq("ready_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            acc_cyc  = cyc;
            in_valid = 1'b0;
        end
    endtask

    task automatic send_img(input int cnt, input bit gap);
        for (int i = 0; i < cnt; i++) begin
            if (gap && i > 0) @(negedge clk);
            send_byte(img[i]);
        end
    endtask

    task automatic pulse_restart(input bit offer);
        @(negedge clk);
        restart = 1'b1;
        if (offer) begin
            in_data  = 8'h93;
            in_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        restart  = 1'b0;
        in_valid = 1'b0;
        clear_log();
    endtask

    task automatic check_two_word_load(input string pfx, input int k);
        check_eq({pfx, "_nwr"}, wa_q.size(), 32'd2);
        if (wa_q.size() >= 2) begin
            check_eq({pfx, "_a0"}, wa_q[0], 32'h0000_0000);
            check_eq({pfx, "_d0"}, wd_q[0], 32'h0010_0513);
            check_eq({pfx, "_a1"}, wa_q[1], 32'h0000_0004);
            check_eq({pfx, "_d1"}, wd_q[1], 32'h0020_0593);
            check_eq({pfx, "_wlat"}, wc_q[1], k);
        end
        check_eq({pfx, "_rel"}, rel_cyc, k + 1);
        check_eq({pfx, "_wl"}, words_loaded, 32'd2);
        check_eq({pfx, "_cpu"}, cpu_rst_n, 32'd1);
        check_eq({pfx, "_rdy"}, in_ready, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        // Reset values
        #2;
        check_eq("rst_rdy", in_ready, 32'd0);
        check_eq("rst_wen", imem_wr_en, 32'd0);
        check_eq("rst_addr", imem_wr_addr, 32'd0);
        check_eq("rst_data", imem_wr_data, 32'd0);
        check_eq("rst_cpu", cpu_rst_n, 32'd0);
        check_eq("rst_err", load_err, 32'd0);
        check_eq("rst_wl", words_loaded, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rdy_after_rst", in_ready, 32'd1);

        // N=2, back-to-back bytes
        img = {8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        send_img(10, 1'b0);
        k = acc_cyc;
        repeat (3) @(negedge clk);
        check_two_word_load("n2", k);

        // Same image with in_valid toggled every other cycle
        pulse_restart(1'b0);
        check_eq("rs_cpu", cpu_rst_n, 32'd0);
        check_eq("rs_wl", words_loaded, 32'd0);
        send_img(10, 1'b1);
        k = acc_cyc;
        repeat (3) @(negedge clk);
        check_two_word_load("gap", k);

        // N=257 exceeds DEPTH
        pulse_restart(1'b0);
        img = {8'h01, 8'h01};
        send_img(2, 1'b0);
        @(negedge clk);
        in_data  = 8'hAA;
        in_valid = 1'b1;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        check_eq("err_flag", load_err, 32'd1);
        check_eq("err_rdy", in_ready, 32'd0);
        check_eq("err_cpu", cpu_rst_n, 32'd0);
        check_eq("err_nwr", wa_q.size(), 32'd0);

        // N=0
        pulse_restart(1'b0);
        check_eq("rs_err_clr", load_err, 32'd0);
        img = {8'h00, 8'h00};
        send_img(2, 1'b0);
        k = acc_cyc;
        repeat (3) @(negedge clk);
        check_eq("n0_nwr", wa_q.size(), 32'd0);
        check_eq("n0_rel", rel_cyc, k + 1);
        check_eq("n0_cpu", cpu_rst_n, 32'd1);

        // Restart with a partial second word, then a fresh N=1 image
        pulse_restart(1'b0);
        img = {8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93};
        send_img(7, 1'b0);
        repeat (2) @(negedge clk);
        check_eq("part_nwr", wa_q.size(), 32'd1);
        if (wd_q.size() >= 1) check_eq("part_d0", wd_q[0], 32'h0010_0513);
        pulse_restart(1'b1);  // byte offered alongside restart must be dropped
        check_eq("part_wl", words_loaded, 32'd0);
        check_eq("part_cpu", cpu_rst_n, 32'd0);
        repeat (2) @(negedge clk);
        check_eq("part_nostrobe", wa_q.size(), 32'd0);
        img = {8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_img(6, 1'b0);
        k = acc_cyc;
        repeat (3) @(negedge clk);
        check_eq("n1_nwr", wa_q.size(), 32'd1);
        if (wa_q.size() >= 1) begin
            check_eq("n1_a0", wa_q[0], 32'h0000_0000);
            check_eq("n1_d0", wd_q[0], 32'hDEAD_BEEF);
        end
        check_eq("n1_rel", rel_cyc, k + 1);
        check_eq("n1_wl", words_loaded, 32'd1);
        check_eq("n1_err", load_err, 32'd0);

        // Async reset while the first write strobe is high
        pulse_restart(1'b0);
        img = {8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00};
        send_img(6, 1'b0);
        check_eq("ar_strobe", imem_wr_en, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("ar_wen", imem_wr_en, 32'd0);
        check_eq("ar_addr", imem_wr_addr, 32'd0);
        check_eq("ar_data", imem_wr_data, 32'd0);
        check_eq("ar_wl", words_loaded, 32'd0);
        check_eq("ar_cpu", cpu_rst_n, 32'd0);
        check_eq("ar_rdy", in_ready, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_log();
        img = {8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        send_img(6, 1'b0);
        k = acc_cyc;
        repeat (3) @(negedge clk);
        check_eq("pr_nwr", wa_q.size(), 32'd1);
        if (wa_q.size() >= 1) begin
            check_eq("pr_a0", wa_q[0], 32'h0000_0000);
            check_eq("pr_d0", wd_q[0], 32'h1234_5678);
        end
        check_eq("pr_rel", rel_cyc, k + 1);
        check_eq("pr_cpu", cpu_rst_n, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
